// File: rtl/zap_fetch_buffer.sv
// zap_fetch_buffer: instruction fetch stage with a prefetch FIFO.
// Issues sequential word fetches on a single-outstanding req/ack bus, buffers
// the returned words and presents the FIFO head to the branch predictor.
// Optional feature macro: ZAP_FETCH_PERF_EN adds the o_bubble_cnt counter.
//
// Handshake: o_instr_req is raised with o_instr_addr and both stay stable
// until the cycle i_instr_ack is seen high; data/abort are valid only in that
// cycle. A request is never withdrawn, so a redirect that arrives while a
// request is pending waits in DRAIN for the stale ack and then discards it.
module zap_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  output logic        o_instr_req,
  output logic [31:0] o_instr_addr,
  input  logic        i_instr_ack,
  input  logic [31:0] i_instr_data,
  input  logic        i_instr_abt,
  input  logic        i_clear_from_writeback,
  input  logic [31:0] i_pc_from_writeback,
  input  logic        i_clear_from_alu,
  input  logic [31:0] i_pc_from_alu,
  input  logic        i_clear_from_decode,
  input  logic [31:0] i_pc_from_decode,
  input  logic        i_stall,
  output logic [31:0] o_inst,
  output logic        o_val,
  output logic        o_abt,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus_8,
  output logic [1:0]  o_dbg_state
`ifdef ZAP_FETCH_PERF_EN
  ,
  output logic [31:0] o_bubble_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2,
    ABORTED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   mem_inst_q [DEPTH];
  logic [31:0]   mem_inst_d [DEPTH];
  logic          mem_abt_q  [DEPTH];
  logic          mem_abt_d  [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];
  logic [31:0]   mem_pc_d   [DEPTH];

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          push;
  logic          pop;
  logic [PW-1:0] count;
  logic [PW-1:0] count_post;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  assign count       = wr_ptr_q - rd_ptr_q;
  assign rd_idx      = rd_ptr_q[AW-1:0];
  assign wr_idx      = wr_ptr_q[AW-1:0];
  assign redirect    = i_clear_from_writeback | i_clear_from_alu | i_clear_from_decode;
  assign redirect_pc = i_clear_from_writeback ? i_pc_from_writeback :
                       i_clear_from_alu       ? i_pc_from_alu       : i_pc_from_decode;

  // Head outputs come straight from storage, forced to zero when empty.
  assign o_val       = (count != '0);
  assign o_inst      = o_val ? mem_inst_q[rd_idx] : 32'd0;
  assign o_abt       = o_val ? mem_abt_q[rd_idx]  : 1'b0;
  assign o_pc        = o_val ? mem_pc_q[rd_idx]   : 32'd0;
  assign o_pc_plus_8 = o_pc + 32'd8;

  assign push         = i_instr_ack & req_q & (state_q == FETCH) & ~redirect;
  assign pop          = o_val & ~i_stall & ~redirect;
  assign count_post   = count + PW'(push) - PW'(pop);
  assign o_instr_req  = req_q;
  assign o_instr_addr = addr_q;
  assign o_dbg_state  = state_q;

  // Next-state logic for FIFO pointers/storage, fetch PC and the fetch FSM.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    mem_inst_d = mem_inst_q;
    mem_abt_d  = mem_abt_q;
    mem_pc_d   = mem_pc_q;

    if (push) begin
      mem_inst_d[wr_idx] = i_instr_abt ? 32'd0 : i_instr_data;
      mem_abt_d[wr_idx]  = i_instr_abt;
      mem_pc_d[wr_idx]   = fetch_pc_q;
      fetch_pc_d         = fetch_pc_q + 32'd4;
    end

    if (redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // A pending request must still complete before the new target goes out.
      state_d    = (req_q & ~i_instr_ack) ? DRAIN : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (push) begin
            if (i_instr_abt)                 state_d = ABORTED;
            else if (count_post == DEPTH_C)  state_d = HOLD;
            else                             state_d = FETCH;
          end
        end
        HOLD:    if (count_post < DEPTH_C) state_d = FETCH;
        DRAIN:   if (i_instr_ack)          state_d = FETCH;
        ABORTED: state_d = ABORTED;
        default: state_d = FETCH;
      endcase
    end

    req_d  = (state_d == FETCH) || (state_d == DRAIN);
    // The drained request keeps its old address on the bus.
    addr_d = (state_d == DRAIN) ? addr_q : fetch_pc_d;
  end

  // State, pointer and storage registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_q[i] <= 32'd0;
        mem_abt_q[i]  <= 1'b0;
        mem_pc_q[i]   <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      mem_inst_q <= mem_inst_d;
      mem_abt_q  <= mem_abt_d;
      mem_pc_q   <= mem_pc_d;
    end
  end

`ifdef ZAP_FETCH_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Count idle predictor cycles that are not caused by a stall or redirect.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (~o_val & ~i_stall & ~redirect & ~(&bubble_cnt_q))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  // Bubble counter register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) bubble_cnt_q <= 32'd0;
    else            bubble_cnt_q <= bubble_cnt_d;
  end

  assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_zap_fetch_buffer.sv
// Bench for zap_fetch_buffer: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the fetch stage.
module tb_zap_fetch_buffer;

  localparam int DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ack;
  logic [31:0] instr_data;
  logic        instr_abt;
  logic        clr_wb, clr_alu, clr_dec;
  logic [31:0] pc_wb, pc_alu, pc_dec;
  logic        stall;
  logic [31:0] inst;
  logic        val;
  logic        abt;
  logic [31:0] pc;
  logic [31:0] pc_plus_8;
  logic [1:0]  dbg_state;
`ifdef ZAP_FETCH_PERF_EN
  logic [31:0] bubble_cnt;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  zap_fetch_buffer #(.RESET_PC(32'd0), .DEPTH(DEPTH)) dut (
    .i_clk                  (clk),
    .i_reset_n              (rst_n),
    .o_instr_req            (instr_req),
    .o_instr_addr           (instr_addr),
    .i_instr_ack            (instr_ack),
    .i_instr_data           (instr_data),
    .i_instr_abt            (instr_abt),
    .i_clear_from_writeback (clr_wb),
    .i_pc_from_writeback    (pc_wb),
    .i_clear_from_alu       (clr_alu),
    .i_pc_from_alu          (pc_alu),
    .i_clear_from_decode    (clr_dec),
    .i_pc_from_decode       (pc_dec),
    .i_stall                (stall),
    .o_inst                 (inst),
    .o_val                  (val),
    .o_abt                  (abt),
    .o_pc                   (pc),
    .o_pc_plus_8            (pc_plus_8),
    .o_dbg_state            (dbg_state)
`ifdef ZAP_FETCH_PERF_EN
    ,
    .o_bubble_cnt           (bubble_cnt)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Buffered entries, oldest first: {inst[64:33], abt[32], pc[31:0]}.
  logic [64:0] exp_q[$];
  logic [31:0] m_pc;          // next sequential fetch address
  logic [31:0] m_drain_addr;  // address of the stale request being drained
  bit          m_req;
  bit          m_drain;
  bit          m_aborted;
  logic [31:0] m_bubble;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_inst, e_pc;
    logic        e_abt;
    e_inst = 32'd0;
    e_pc   = 32'd0;
    e_abt  = 1'b0;
    if (exp_q.size() > 0) begin
      e_inst = exp_q[0][64:33];
      e_abt  = exp_q[0][32];
      e_pc   = exp_q[0][31:0];
    end
    check_eq("req", {31'd0, instr_req}, {31'd0, m_req});
    if (m_req) check_eq("addr", instr_addr, m_drain ? m_drain_addr : m_pc);
    check_eq("val", {31'd0, val}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
    check_eq("inst", inst, e_inst);
    check_eq("abt", {31'd0, abt}, {31'd0, e_abt});
    check_eq("pc", pc, e_pc);
    check_eq("pc_plus_8", pc_plus_8, e_pc + 32'd8);
`ifdef ZAP_FETCH_PERF_EN
    check_eq("bubble_cnt", bubble_cnt, m_bubble);
`endif
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input bit ack, input logic [31:0] data, input bit ab, input bit stl,
                            input bit wb, input logic [31:0] pwb, input bit alu,
                            input logic [31:0] palu, input bit dec, input logic [31:0] pdec);
    bit          redirect;
    logic [31:0] tgt;
    redirect = wb | alu | dec;
    tgt      = wb ? pwb : (alu ? palu : pdec);
    if (exp_q.size() == 0 && !stl && !redirect && m_bubble != 32'hFFFF_FFFF)
      m_bubble = m_bubble + 32'd1;
    if (redirect) begin
      exp_q.delete();
      if (m_req && !ack) begin
        if (!m_drain) m_drain_addr = m_pc;
        m_drain = 1'b1;
      end else begin
        m_drain = 1'b0;
      end
      m_pc      = tgt & ~32'd3;
      m_aborted = 1'b0;
    end else begin
      if (exp_q.size() > 0 && !stl) void'(exp_q.pop_front());
      if (ack) begin
        if (m_drain) begin
          m_drain = 1'b0;
        end else begin
          exp_q.push_back({ab ? 32'd0 : data, ab, m_pc});
          m_pc = m_pc + 32'd4;
          if (ab) m_aborted = 1'b1;
        end
      end
    end
    m_req = m_drain || (!m_aborted && exp_q.size() < DEPTH);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    instr_ack  = 1'b0;
    instr_data = 32'd0;
    instr_abt  = 1'b0;
    clr_wb     = 1'b0;
    clr_alu    = 1'b0;
    clr_dec    = 1'b0;
    pc_wb      = 32'd0;
    pc_alu     = 32'd0;
    pc_dec     = 32'd0;
    stall      = 1'b0;
  endtask

  // One clock: drive at the negedge, update the model, check at the next negedge.
  // The bus responder only acks while a request is expected on the bus.
  task automatic cycle(input bit ack, input bit ab, input bit stl,
                       input bit wb, input logic [31:0] pwb, input bit alu,
                       input logic [31:0] palu, input bit dec, input logic [31:0] pdec);
    logic [31:0] data;
    data       = $urandom;
    instr_ack  = ack & m_req;
    instr_data = data;
    instr_abt  = ab & ack & m_req;
    stall      = stl;
    clr_wb     = wb;
    pc_wb      = pwb;
    clr_alu    = alu;
    pc_alu     = palu;
    clr_dec    = dec;
    pc_dec     = pdec;
    model_step(instr_ack, data, instr_abt, stl, wb, pwb, alu, palu, dec, pdec);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic apply_reset();
    drive_idle();
    #3 rst_n = 1'b0;
    exp_q.delete();
    m_pc         = 32'd0;
    m_drain_addr = 32'd0;
    m_req        = 1'b0;
    m_drain      = 1'b0;
    m_aborted    = 1'b0;
    m_bubble     = 32'd0;
    #1 check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);

    // Sequential fetch with an ack every cycle: head PC walks 0, 4, 8.
    apply_reset();
    idle_cycle();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      check_eq("seq_pc", pc, 32'(i * 4));
      check_eq("seq_pc_plus_8", pc_plus_8, 32'(i * 4 + 8));
    end

    // Stall fills the FIFO, fetch holds; one pop re-opens fetching.
    apply_reset();
    idle_cycle();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("hold_req", {31'd0, instr_req}, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("hold_req2", {31'd0, instr_req}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("refetch_req", {31'd0, instr_req}, 32'd1);
    check_eq("refetch_head", pc, 32'd4);

    // ALU redirect while a request is pending: drain the old fetch first.
    apply_reset();
    idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h100, 1'b0, 32'd0);
    check_eq("drain_addr", instr_addr, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("drain_val", {31'd0, val}, 32'd0);
    check_eq("redir_addr", instr_addr, 32'h100);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("redir_head", pc, 32'h100);

    // Writeback beats ALU when both clear together.
    apply_reset();
    idle_cycle();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'd0);
    check_eq("prio_addr", instr_addr, 32'h200);
    check_eq("prio_val", {31'd0, val}, 32'd0);

    // Prefetch abort on 0x8 stops fetching until a decode clear.
    apply_reset();
    idle_cycle();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("abt_req", {31'd0, instr_req}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("abt_flag", {31'd0, abt}, 32'd1);
    check_eq("abt_inst", inst, 32'd0);
    check_eq("abt_pc", pc, 32'h8);
    check_eq("abt_req_idle", {31'd0, instr_req}, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h40);
    check_eq("abt_exit_req", {31'd0, instr_req}, 32'd1);
    check_eq("abt_exit_addr", instr_addr, 32'h40);

    // Fetch address wraps at 2^32; PC+8 wraps too.
    apply_reset();
    idle_cycle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFE);
    check_eq("wrap_req_addr", instr_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("wrap_pc", pc, 32'hFFFF_FFFC);
    check_eq("wrap_pc_plus_8", pc_plus_8, 32'h0000_0004);
    check_eq("wrap_next_addr", instr_addr, 32'h0000_0000);

    // Randomized traffic, with a reset dropped in the middle of the run.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          r_ack, r_abt, r_stl, r_wb, r_alu, r_dec;
      logic [31:0] t_wb, t_alu, t_dec;
      if (i == 1500) apply_reset();
      r_ack = ($urandom_range(0, 9) < 6);
      r_abt = ($urandom_range(0, 19) == 0);
      r_stl = ($urandom_range(0, 9) < 4);
      r_wb  = ($urandom_range(0, 24) == 0);
      r_alu = ($urandom_range(0, 24) == 0);
      r_dec = ($urandom_range(0, 24) == 0);
      t_wb  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      t_alu = $urandom;
      t_dec = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      cycle(r_ack, r_abt, r_stl, r_wb, t_wb, r_alu, t_alu, r_dec, t_dec);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
